// File: rtl/return_stack_if.sv
// return_stack_if: bundles the return-address stack command and status signals.
//
// Signals:
//   push, pop  - commands, sampled on the rising clock edge
//   in         - return address written by push / push+pop
//   out        - current top entry (0 when empty)
//   count      - number of valid entries, 0..DEPTH
//   empty/full - decodes of count
//   overflow   - sticky, set by a push into a full stack
//   underflow  - sticky, set by a pop from an empty stack
//
// Handshake: there is no valid/ready pair. The stack never stalls; any
// push/pop present at a rising edge is acted on at that edge. Status outputs
// depend only on registered state, so the master may read them at any time.
interface return_stack_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, in,
        input  out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, in,
        output out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses that sits beside the program counter.
// A call pushes PC+1; a return loads the PC from out and pops in the same cycle.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears pointer and sticky flags only
//   bus   - return_stack_if.slave (push, pop, in, out, count, empty, full,
//           overflow, underflow)
module return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    return_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic             overflow_q;
    logic             underflow_q;

    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             wr_en;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == CW'(DEPTH));
    // Wraps to DEPTH-1 when empty; out is gated by is_empty so that is harmless.
    assign top_idx  = AW'(sp - CW'(1));

    // A push+pop on a non-empty stack overwrites the top in place; every other
    // accepted push lands at sp (which is 0 for push+pop on an empty stack).
    assign wr_idx = (bus.pop && !is_empty) ? top_idx : sp[AW-1:0];
    assign wr_en  = !reset && bus.push && (bus.pop || !is_full);

    // Storage is deliberately not reset; empty gates the stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp          <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            unique case ({bus.push, bus.pop})
                2'b10: begin
                    if (is_full) overflow_q <= 1'b1;
                    else         sp <= sp + CW'(1);
                end
                2'b01: begin
                    if (is_empty) underflow_q <= 1'b1;
                    else          sp <= sp - CW'(1);
                end
                2'b11: begin
                    // Tail-call replace: only an empty stack changes depth.
                    if (is_empty) sp <= CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.out       = is_empty ? '0 : mem[top_idx];
    assign bus.count     = sp;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: self-checking bench for return_stack. A queue-based
// reference stack produces the expected status word for every edge driven;
// each test pops those expectations and compares, plus fixed-value checks.
module tb_return_stack;
    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int ST_W  = WIDTH + CW + 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    return_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    return_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // tiny program counter, loaded from the stack on a return
    logic             pc_load = 1'b0;
    logic [WIDTH-1:0] pc = '0;
    always @(posedge clk) begin
        if (pc_load) pc <= bus.out;
    end

    // reference model and scoreboard
    logic [WIDTH-1:0] model_stk[$];
    logic             model_ovf = 1'b0;
    logic             model_unf = 1'b0;
    logic [ST_W-1:0]  exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [ST_W-1:0] got;
    logic [ST_W-1:0] want;

    function automatic logic [ST_W-1:0] status();
        return {bus.out, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow};
    endfunction

    function automatic logic [ST_W-1:0] model_status();
        logic [WIDTH-1:0] top;
        int n;
        n   = model_stk.size();
        top = (n == 0) ? '0 : model_stk[n-1];
        return {top, CW'(n), (n == 0), (n == DEPTH), model_ovf, model_unf};
    endfunction

    // driver: one edge with reset asserted
    task automatic drive_reset(input logic p, input logic [WIDTH-1:0] d);
        reset    = 1'b1;
        bus.push = p;
        bus.pop  = 1'b0;
        bus.in   = d;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        bus.push = 1'b0;
        model_stk.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        exp_q.push_back(model_status());
    endtask

    // driver: one edge with the given command
    task automatic drive_op(input logic p, input logic q, input logic [WIDTH-1:0] d);
        int n;
        bus.push = p;
        bus.pop  = q;
        bus.in   = d;
        n = model_stk.size();
        if (p && !q) begin
            if (n == DEPTH) model_ovf = 1'b1;
            else            model_stk.push_back(d);
        end else if (!p && q) begin
            if (n == 0) model_unf = 1'b1;
            else        void'(model_stk.pop_back());
        end else if (p && q) begin
            if (n == 0) model_stk.push_back(d);
            else        model_stk[n-1] = d;
        end
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        exp_q.push_back(model_status());
    endtask

    task automatic test_reset();
        drive_reset(1'b0, '0);
        void'(exp_q.pop_front());
        drive_op(1'b1, 1'b0, 16'h5555);
        void'(exp_q.pop_front());
        drive_reset(1'b1, 16'h1234);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL reset_model got=%h want=%h", got, want);
        end
        tests_run++;
        if (got !== {16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_values got=%h want=%h", got, {16'h0000, 4'd0, 4'b1000});
        end
    endtask

    task automatic test_lifo();
        logic [WIDTH-1:0] vals [3];
        logic [WIDTH-1:0] pops [3];
        vals = '{16'h0010, 16'h0020, 16'h0030};
        pops = '{16'h0020, 16'h0010, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b1, 1'b0, vals[i]);
            got = status(); want = exp_q.pop_front();
            tests_run++;
            if (got !== want || bus.out !== vals[i]) begin
                tests_failed++;
                $display("FAIL lifo_push%0d got=%h want=%h out_want=%h", i, got, want, vals[i]);
            end
        end
        tests_run++;
        if (bus.count !== CW'(3)) begin
            tests_failed++;
            $display("FAIL lifo_count got=%0d want=3", bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b0, 1'b1, '0);
            got = status(); want = exp_q.pop_front();
            tests_run++;
            if (got !== want || bus.out !== pops[i]) begin
                tests_failed++;
                $display("FAIL lifo_pop%0d got=%h want=%h out_want=%h", i, got, want, pops[i]);
            end
        end
        tests_run++;
        if (bus.empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL lifo_empty got=%b want=1", bus.empty);
        end
    endtask

    task automatic test_fill_overflow();
        drive_reset(1'b0, '0);
        void'(exp_q.pop_front());
        for (int i = 1; i <= DEPTH; i++) begin
            drive_op(1'b1, 1'b0, WIDTH'(i));
            got = status(); want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL fill%0d got=%h want=%h", i, got, want);
            end
        end
        tests_run++;
        if (bus.full !== 1'b1 || bus.out !== 16'h0008) begin
            tests_failed++;
            $display("FAIL fill_full full=%b out=%h want full=1 out=0008", bus.full, bus.out);
        end
        drive_op(1'b1, 1'b0, 16'hFFFF);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want || bus.overflow !== 1'b1 || bus.out !== 16'h0008 || bus.count !== CW'(8)) begin
            tests_failed++;
            $display("FAIL overflow_push got=%h want=%h", got, want);
        end
        drive_op(1'b0, 1'b1, '0);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want || bus.out !== 16'h0007 || bus.overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_sticky got=%h want=%h", got, want);
        end
    endtask

    task automatic test_underflow();
        drive_reset(1'b0, '0);
        void'(exp_q.pop_front());
        drive_op(1'b0, 1'b1, '0);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want || bus.underflow !== 1'b1 || bus.count !== '0 || bus.out !== '0) begin
            tests_failed++;
            $display("FAIL underflow_pop got=%h want=%h", got, want);
        end
        drive_op(1'b1, 1'b0, 16'h00AA);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want || bus.out !== 16'h00AA || bus.underflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL underflow_sticky got=%h want=%h", got, want);
        end
        drive_reset(1'b0, '0);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want || bus.underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow_clear got=%h want=%h", got, want);
        end
    endtask

    task automatic test_simultaneous();
        drive_op(1'b1, 1'b0, 16'h0010);
        void'(exp_q.pop_front());
        drive_op(1'b1, 1'b0, 16'h0020);
        void'(exp_q.pop_front());
        drive_op(1'b1, 1'b1, 16'h0099);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want || got !== {16'h0099, 4'd2, 4'b0000}) begin
            tests_failed++;
            $display("FAIL replace_top got=%h want=%h", got, want);
        end
        drive_op(1'b0, 1'b1, '0);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want || bus.out !== 16'h0010) begin
            tests_failed++;
            $display("FAIL replace_below got=%h want=%h", got, want);
        end
        drive_reset(1'b0, '0);
        void'(exp_q.pop_front());
        drive_op(1'b1, 1'b1, 16'h0042);
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (got !== want || got !== {16'h0042, 4'd1, 4'b0000}) begin
            tests_failed++;
            $display("FAIL replace_empty got=%h want=%h", got, want);
        end
    endtask

    task automatic test_call_return();
        drive_reset(1'b0, '0);
        void'(exp_q.pop_front());
        drive_op(1'b1, 1'b0, 16'h0101);
        void'(exp_q.pop_front());
        pc_load = 1'b1;
        drive_op(1'b0, 1'b1, '0);
        pc_load = 1'b0;
        got = status(); want = exp_q.pop_front();
        tests_run++;
        if (pc !== 16'h0101 || got !== want || bus.empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL call_return pc=%h want=0101 status=%h want=%h", pc, got, want);
        end
    endtask

    task automatic test_back_to_back();
        logic p, q;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                drive_reset(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 65535)));
            end else begin
                p = 1'($urandom_range(0, 1));
                q = 1'($urandom_range(0, 1));
                drive_op(p, q, WIDTH'($urandom_range(0, 65535)));
            end
            got = status(); want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL b2b_%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.in   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lifo();
        test_fill_overflow();
        test_underflow();
        test_simultaneous();
        test_call_return();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack, the consumer and restorer of program-counter values. On a call, the core pushes the return address (PC+1). On a return, the core reads the top entry, drives it into the program counter's `in` with `load=1`, and pops in the same cycle. The block sits beside the program counter and its increment path in the CPU datapath and holds DEPTH 16-bit addresses in LIFO order.

## Interface
- `DEPTH`, 8: number of entries; legal values 2..16, power of two.
- `WIDTH`, 16: entry width; must equal the program counter width.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `push`  in  1: write `in` as the new top entry.
- `pop`  in  1: discard the top entry.
- `in`  in  WIDTH: return address to push.
- `out`  out  WIDTH: current top entry; 0 when empty.
- `count`  out  log2(DEPTH)+1: number of valid entries, 0..DEPTH.
- `empty`  out  1: `count==0`.
- `full`  out  1: `count==DEPTH`.
- `overflow`  out  1: sticky; set by a push into a full stack.
- `underflow`  out  1: sticky; set by a pop from an empty stack.

## Operation
- State:
  - storage array `mem[0..DEPTH-1]`;
  - pointer `sp`, equal to `count`, 0..DEPTH;
  - the two sticky error bits.
- Top entry is `mem[sp-1]`.
- `out`, `empty`, `full` and `count` are combinational decodes of registered state only. They never depend combinationally on `push`, `pop` or `in`.
- Per-edge actions, evaluated in priority order:
  - `reset=1`: `sp<=0`, `overflow<=0`, `underflow<=0`. `mem` contents are not cleared; `out` is gated to 0 by `empty`. `push` and `pop` are ignored that cycle.
  - `push=1`, `pop=0`:
    - not full: `mem[sp]<=in`, `sp<=sp+1`.
    - full: no change to `mem` or `sp`, `overflow<=1`.
  - `push=0`, `pop=1`:
    - not empty: `sp<=sp-1`.
    - empty: no change, `underflow<=1`.
  - `push=1`, `pop=1` (tail-call replace):
    - not empty: `mem[sp-1]<=in`, `sp` unchanged. No error flag, even when full.
    - empty: behaves as a plain push (`mem[0]<=in`, `sp<=1`). No underflow.
  - Neither asserted: hold all state.
- No wrap-around. The pointer saturates at 0 and DEPTH, and erroneous operations are dropped.
- Sticky flags clear only on `reset`.

## Timing
- Reset values: `out=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `underflow=0`.
- Push latency is 1 cycle. A value pushed at edge N appears on `out` after edge N.
- Pop read latency is 0 cycles. `out` is valid before the edge in which `pop` is asserted, so the core can load the program counter from `out` at that same edge. After the edge, `out` shows the next-lower entry, or 0 if the stack is now empty.
- `count`, `empty` and `full` update at the same edge as `sp`.
- Back-to-back push/pop on every cycle is supported; there are no stall or bubble cycles.
- A `reset` asserted mid-sequence takes effect at that edge. Any concurrent `push` or `pop` is lost.

## Test plan
- **Reset:** assert `reset` for 1 cycle with `push=1`, `in=16'h1234` -> `count=0`, `empty=1`, `out=0`, both flags 0.
- **LIFO order:** push 16'h0010, 16'h0020, 16'h0030 on consecutive cycles -> `out` reads 0010, 0020, 0030 after each edge, `count=3`. Then pop three times -> `out` reads 0020, 0010, 0 and `empty=1`.
- **Fill and overflow (DEPTH=8):** push 16'h0001..16'h0008 -> `full=1`, `out=0008`. Push 16'hFFFF -> `overflow=1`, `out` stays 0008, `count` stays 8. Then pop -> `out=0007` and `overflow` remains 1.
- **Underflow:** from empty, pop -> `underflow=1`, `count=0`, `out=0`. Next, push 16'h00AA -> `out=00AA` and `underflow` remains 1 until `reset`.
- **Simultaneous push and pop:**
  - with `count=2` and top 16'h0020, assert both with `in=16'h0099` -> `out=0099`, `count=2`, no flags;
  - on an empty stack, assert both with `in=16'h0042` -> `count=1`, `out=0042`, `underflow=0`.
- **Call/return with the program counter:** push PC+1=16'h0101. Then, in one cycle, drive PC `in=out`, `load=1`, `pop=1` -> PC reads 0101 after that edge and the stack is empty.
